// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter: issues one candidate per reservation-station bank to shared units with round-robin on contested ones
`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 6
`endif
module rs_issue_arbiter #(
  parameter int MULT_LAT = 4,
  parameter int TAG_W    = `PREG_IDX_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0][1:0]       req_fu,
  input  logic [1:0][TAG_W-1:0] req_tag,
  input  logic                  lsq_stall,
  input  logic                  br_stall,
  input  logic                  flush,
  output logic [1:0]            grant,
  output logic [1:0]            iss_valid,
  output logic [1:0][1:0]       iss_fu,
  output logic [1:0][TAG_W-1:0] iss_tag,
  output logic                  mult_busy,
  output logic [2:0]            rr_ptr
);
  logic [3:0] mult_cnt;
  logic [1:0] ok;
  logic       contend;
  logic       pri;
  logic [3:0] ptr_ext;
  logic [3:0] ptr_flip;
  logic       mult_grant;
  function automatic logic unit_free(input logic [1:0] fu, input logic ls, input logic bs, input logic mb);
    return fu == 2'd0 || (fu == 2'd1 && !ls) || (fu == 2'd2 && !mb) || (fu == 2'd3 && !bs);
  endfunction
  assign mult_busy = mult_cnt != 4'd0;
  always_comb begin
    for (int i = 0; i < 2; i++)
      ok[i] = req_valid[i] && !flush && reset && unit_free(req_fu[i], lsq_stall, br_stall, mult_busy);
    contend = &ok && req_fu[0] == req_fu[1] && req_fu[0] != 2'd0;
    ptr_ext = {rr_ptr, 1'b0};
    pri = ptr_ext[req_fu[0]];
    grant[0] = ok[0] && !(contend && pri);
    grant[1] = ok[1] && !(contend && !pri);
    ptr_flip = contend ? 4'b0001 << req_fu[0] : 4'b0000;
    mult_grant = (grant[0] && req_fu[0] == 2'd2) || (grant[1] && req_fu[1] == 2'd2);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      iss_valid <= '0;
      iss_fu    <= '0;
      iss_tag   <= '0;
      mult_cnt  <= '0;
      rr_ptr    <= '0;
    end else begin
      iss_valid <= grant;
      for (int i = 0; i < 2; i++)
        if (grant[i]) begin
          iss_fu[i]  <= req_fu[i];
          iss_tag[i] <= req_tag[i];
        end
      rr_ptr   <= rr_ptr ^ ptr_flip[3:1];
      mult_cnt <= flush ? 4'd0 : mult_grant ? 4'(MULT_LAT - 1) : mult_busy ? mult_cnt - 4'd1 : mult_cnt;
    end
endmodule

// File: doc/rs_issue_arbiter.md
Name: rs_issue_arbiter

Overview:
- Schedules issue from the two reservation-station banks to the shared functional units: 2 ALUs, 1 LSQ port, 1 multiplier and 1 branch unit.
- Each cycle, each bank presents at most one ready candidate. The arbiter returns a same-cycle grant, which pops the bank entry, and registers the issued instruction toward execute.
- Round-robin pointers give fairness on contested single-instance units. A countdown tracks multiplier occupancy.

Parameters:
- MULT_LAT, 4, cycles between successive multiplier issues (non-pipelined multiplier); legal range 1..15.
- TAG_W, `PREG_IDX_WIDTH, width of the destination physical-register tag.

Ports:
- clock, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low; asserted while 0.
- req_valid, input, [1:0], bank i has a ready candidate.
- req_fu, input, [1:0][1:0], unit type per bank: 0=ALU, 1=LSQ, 2=MULT, 3=BR.
- req_tag, input, [1:0][TAG_W-1:0], destination tag of the candidate.
- lsq_stall, input, 1, LSQ cannot accept this cycle.
- br_stall, input, 1, branch unit cannot accept this cycle.
- flush, input, 1, squash (branch mispredict).
- grant, output, [1:0], combinational; bank i pops its candidate this cycle.
- iss_valid, output, [1:0], registered; lane i holds an issued instruction.
- iss_fu, output, [1:0][1:0], registered unit type per lane.
- iss_tag, output, [1:0][TAG_W-1:0], registered tag per lane.
- mult_busy, output, 1, multiplier occupied (mult_cnt != 0).
- rr_ptr, output, [2:0], priority bank for {BR, MULT, LSQ}; bit 0 = LSQ.

Behaviour:
- Reset (reset=0, asynchronous):
  - iss_valid=0, iss_fu=0, iss_tag=0.
  - mult_cnt=0, all rr_ptr bits=0 (bank 0 priority).
  - grant=0 while reset is asserted.
- grant[i] requires req_valid[i]=1 and flush=0. It is further qualified by unit type:
  - ALU: always granted; both banks may issue ALU ops in the same cycle.
  - LSQ: requires lsq_stall=0.
  - BR: requires br_stall=0.
  - MULT: requires mult_cnt=0.
- Contention: both banks request the same single-instance unit and the unit is available.
  - Grant the bank equal to that unit's rr_ptr bit; the other bank gets grant=0 and must hold its candidate.
  - At the clock edge, invert that rr_ptr bit.
- No pointer change on an uncontested grant, a stalled unit, or flush.
- Different unit types never conflict. For example, bank0 LSQ plus bank1 MULT are both granted in the same cycle if both units are available.
- Issue register, at each edge:
  - iss_valid[i] <= grant[i].
  - When grant[i]=1, iss_fu[i] <= req_fu[i] and iss_tag[i] <= req_tag[i]; otherwise both hold their values.
  - Latency: request to iss_valid is 1 cycle.
- Multiplier countdown:
  - On a MULT grant, mult_cnt <= MULT_LAT-1.
  - Otherwise, if mult_cnt != 0, mult_cnt decrements by 1.
  - Result: a grant at cycle t permits the next MULT grant at cycle t+MULT_LAT. With MULT_LAT=1, mult_busy is never asserted.
  - mult_cnt is 4 bits and saturates at 0; it never wraps.
- Flush:
  - grant=0 in the flush cycle.
  - Next edge: iss_valid=0 and mult_cnt=0 (in-flight multiply squashed).
  - rr_ptr, iss_fu and iss_tag are retained.
  - A flush concurrent with a stall has no additional effect.
- Stall interaction: the stall inputs are sampled combinationally in the same cycle. A stalled unit yields grant=0 for every bank requesting it, with no pointer update.
- All four req_fu encodings are valid; there is no illegal-code handling.

Test Plan:
- Reset release, then both banks request ALU with tags 5 and 9 → grant=2'b11 same cycle; next cycle iss_valid=2'b11, iss_fu=0/0, iss_tag=5/9; rr_ptr=0.
- Both banks request LSQ for 4 consecutive cycles, candidates held → grant sequence 01,10,01,10; rr_ptr[0] toggles every cycle; each tag issued exactly once per grant.
- MULT_LAT=4: bank0 MULT granted at cycle t; bank1 MULT requests from t+1 → mult_busy=1 at t+1..t+3, bank1 granted at t+4 and not before.
- bank0 BR with br_stall=1 for 3 cycles, then 0 → grant[0]=0 for 3 cycles, then 1; rr_ptr[2] unchanged.
- MULT granted (mult_cnt=3), then flush=1 with both banks requesting ALU → grant=00; next cycle iss_valid=00, mult_busy=0; a new MULT request on the following cycle is granted immediately.
- Reset driven to 0 mid-stream while iss_valid=11 and rr_ptr=3'b101 → all outputs clear immediately, without waiting for a clock edge.
